mac_datapath: RTL and testbench

- Datapath stage directly downstream of the FSM controller. It consumes the controller's 16-bit control word each cycle and executes operand loads, multiply, accumulate and result hand-off.
- Signed multiply-accumulate on W-bit operands. Finished results are queued in a 2-entry output buffer and drained over a valid/ready handshake.
- Exposes in_ready so upstream logic can hold off the controller's start while the buffer is full.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_out_fifo.sv | 50 +++++
 rtl/mac_datapath.sv | 115 +++++++++++
 tb/tb_mac_datapath.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath: control-word bit positions, SEL codes, default widths.
// No logic; imported by mac_datapath and mac_out_fifo.
// No flow control of its own.
package mac_pkg;
    localparam int W_DEF     = 9;
    localparam int ACC_W_DEF = 2 * W_DEF + 2;

    localparam int LD_A    = 15;
    localparam int LD_B    = 14;
    localparam int LD_C    = 13;
    localparam int LD_P    = 12;
    localparam int LD_S    = 11;
    localparam int CLR_S   = 10;
    localparam int DONE    = 5;
    localparam int SEL_MSB = 4;
    localparam int SEL_LSB = 3;
    localparam int SUB     = 2;

    localparam logic [1:0] SEL_AB = 2'b00;
    localparam logic [1:0] SEL_AC = 2'b01;
    localparam logic [1:0] SEL_BC = 2'b10;
    localparam logic [1:0] SEL_AA = 2'b11;
endpackage

// File: rtl/mac_out_fifo.sv
// Result buffer: synchronous FIFO with occupancy count and full/empty flags.
// Latency: a push is visible at the head one cycle later; o_dat is the registered head entry.
// Backpressure: the caller gates i_push/i_pop; push and pop in one cycle leave the count unchanged.
module mac_out_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_push_dat,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/mac_datapath.sv
// Signed MAC datapath driven by a 16-bit control word; results queue in mac_out_fifo. Optional MAC_SAT_EN: saturating accumulate.
// Latency: operand->P 1 cycle, P->S 1 cycle, DONE->out_valid 1 cycle (no bypass).
// Backpressure: in_ready=!full; DONE while full without a same-cycle pop drops the result and sets sticky drop_err.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int ACC_W      = 2 * W + 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      control,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_c,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop_err
);
    logic signed [W-1:0]     r_a, r_b, r_c;
    logic signed [2*W-1:0]   r_p;
    logic signed [ACC_W-1:0] r_s;
    logic                    r_drop;

    logic signed [W-1:0]     w_x, w_y;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_s_next;

    logic [ACC_W-1:0]            w_fifo_dat;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_full, w_empty, w_push, w_pop, w_drop;
    logic                        w_unused;

    always_comb begin
        w_x = r_a;
        w_y = r_b;
        case (control[SEL_MSB:SEL_LSB])
            SEL_AB:  begin w_x = r_a; w_y = r_b; end
            SEL_AC:  begin w_x = r_a; w_y = r_c; end
            SEL_BC:  begin w_x = r_b; w_y = r_c; end
            default: begin w_x = r_a; w_y = r_a; end
        endcase
    end

    assign w_prod  = (2*W)'(w_x) * (2*W)'(w_y);
    assign w_p_ext = ACC_W'(r_p);

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] w_wide;

    assign w_wide = control[SUB] ? (ACC_W+1)'(r_s) - (ACC_W+1)'(w_p_ext)
                                 : (ACC_W+1)'(r_s) + (ACC_W+1)'(w_p_ext);

    // Disagreeing top two bits of the widened sum mean it left the ACC_W range.
    always_comb begin
        w_s_next = w_wide[ACC_W-1:0];
        if (w_wide[ACC_W] != w_wide[ACC_W-1])
            w_s_next = w_wide[ACC_W] ? S_MIN : S_MAX;
    end
`else
    assign w_s_next = control[SUB] ? r_s - w_p_ext : r_s + w_p_ext;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_p    <= '0;
            r_s    <= '0;
            r_drop <= 1'b0;
        end else begin
            if (control[LD_A]) r_a <= in_a;
            if (control[LD_B]) r_b <= in_b;
            if (control[LD_C]) r_c <= in_c;
            if (control[LD_P]) r_p <= w_prod;
            if (control[CLR_S])     r_s <= '0;
            else if (control[LD_S]) r_s <= w_s_next;
            if (w_drop) r_drop <= 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a DONE into a full buffer still lands.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = control[DONE] && (!w_full || w_pop);
    assign w_drop = control[DONE] && w_full && !w_pop;

    mac_out_fifo #(
        .DW    (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (r_s),
        .i_pop      (w_pop),
        .o_dat      (w_fifo_dat),
        .o_count    (w_fifo_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_fifo_dat;
    assign drop_err  = r_drop;

    assign w_unused = ^{control[9:6], control[1:0], w_fifo_count};
endmodule

// File: tb/tb_mac_datapath.sv
// Directed bench for mac_datapath: queue-based reference model checked every cycle, plus literal anchors.
// Honours MAC_SAT_EN to pick the saturating or wrapping accumulate expectation.
module tb_mac_datapath;
    localparam int W     = 9;
    localparam int ACC_W = 2 * W + 2;

    localparam logic [15:0] C_LDA  = 16'h8000;
    localparam logic [15:0] C_LDB  = 16'h4000;
    localparam logic [15:0] C_LDC  = 16'h2000;
    localparam logic [15:0] C_LDP  = 16'h1000;
    localparam logic [15:0] C_LDS  = 16'h0800;
    localparam logic [15:0] C_CLR  = 16'h0400;
    localparam logic [15:0] C_DONE = 16'h0020;
    localparam logic [15:0] C_SUB  = 16'h0004;
    localparam logic [15:0] C_S01  = 16'h0008;
    localparam logic [15:0] C_S11  = 16'h0018;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      control;
    logic [W-1:0]     in_a, in_b, in_c;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             drop_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    int tb_a, tb_b, tb_c;
    longint m_a, m_b, m_c, m_p, m_s;
    longint q[$];
    bit m_drop;

    mac_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .control   (control),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint acc_fix(input longint v);
        longint lim;
        lim = longint'(1) << (ACC_W - 1);
`ifdef MAC_SAT_EN
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
`else
        v = v & ((lim << 1) - 1);
        if (v >= lim) v = v - (lim << 1);
        return v;
`endif
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_p = 0; m_s = 0;
        q.delete();
        m_drop = 0;
    endtask

    task automatic set_ops(input int a, input int b, input int c);
        tb_a = a; tb_b = b; tb_c = c;
    endtask

    // Drive one control word for one clock and advance the model by the same rules.
    task automatic step(input logic [15:0] ctl, input bit ordy);
        longint na, nb, nc, np, ns, prod;
        bit pop, full;
        control   = ctl;
        in_a      = tb_a[W-1:0];
        in_b      = tb_b[W-1:0];
        in_c      = tb_c[W-1:0];
        out_ready = ordy;
        na = ctl[15] ? longint'(tb_a) : m_a;
        nb = ctl[14] ? longint'(tb_b) : m_b;
        nc = ctl[13] ? longint'(tb_c) : m_c;
        case (ctl[4:3])
            2'd0:    prod = m_a * m_b;
            2'd1:    prod = m_a * m_c;
            2'd2:    prod = m_b * m_c;
            default: prod = m_a * m_a;
        endcase
        np = ctl[12] ? prod : m_p;
        ns = m_s;
        if (ctl[10]) ns = 0;
        else if (ctl[11]) ns = acc_fix(ctl[2] ? m_s - m_p : m_s + m_p);
        pop  = (q.size() > 0) && ordy;
        full = (q.size() == 2);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (ctl[5]) begin
            if (!full || pop) q.push_back(m_s);
            else m_drop = 1;
        end
        m_a = na; m_b = nb; m_c = nc; m_p = np; m_s = ns;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", longint'(out_valid), longint'(q.size() != 0));
            chk("in_ready", longint'(in_ready), longint'(q.size() < 2));
            chk("drop_err", longint'(drop_err), longint'(m_drop));
            chk("out_data", longint'($signed(out_data)), (q.size() != 0) ? q[0] : 0);
        end
    end

    initial begin
        rst = 1'b1; control = '0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        set_ops(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_data", longint'($signed(out_data)), 0);
        rst = 1'b0;

        // Basic MAC, A=3 B=-4 C=5
        set_ops(3, -4, 5);
        step(C_CLR, 0);
        step(C_LDA | C_LDB | C_LDC, 0);
        step(C_LDP, 0);
        chk("model_p_ab", m_p, -12);
        step(C_LDS, 0);
        chk("model_s_ab", m_s, -12);
        step(C_LDP | C_S01, 0);
        chk("model_p_ac", m_p, 15);
        step(C_LDS | C_SUB, 0);
        chk("model_s_sub", m_s, -27);
        chk("pre_done_valid", longint'(out_valid), 0);
        step(C_DONE, 0);
        chk("mac_valid", longint'(out_valid), 1);
        chk("mac_result", longint'($signed(out_data)), -27);
        step(16'h0000, 1);

        // Same-cycle hazards: S=10, P=5
        set_ops(5, 1, 0);
        step(C_CLR | C_LDA | C_LDB, 0);
        step(C_LDP, 0);
        step(C_LDS, 0);
        step(C_LDS, 0);
        step(C_LDS | C_DONE, 0);
        chk("hazard_pushed_old_s", longint'($signed(out_data)), 10);
        chk("hazard_s_after", m_s, 15);
        step(C_CLR | C_LDS, 1);
        step(C_DONE, 0);
        chk("clr_priority", longint'($signed(out_data)), 0);
        step(16'h0000, 1);

        // Full buffer with simultaneous pop: entries 6, 12 then DONE+pop pushes 18
        set_ops(2, 3, 0);
        step(C_CLR | C_LDA | C_LDB, 0);
        step(C_LDP, 0);
        step(C_LDS, 0);
        step(C_DONE | C_LDS, 0);
        step(C_DONE | C_LDS, 0);
        step(C_DONE, 1);
        chk("fullpop_in_ready", longint'(in_ready), 0);
        chk("fullpop_drop", longint'(drop_err), 0);
        chk("fullpop_head", longint'($signed(out_data)), 12);
        step(16'h0000, 1);
        chk("fullpop_tail", longint'($signed(out_data)), 18);
        step(16'h0000, 1);

        // Overflow: S=1,2,3 with out_ready low
        set_ops(1, 1, 0);
        step(C_CLR | C_LDA | C_LDB, 0);
        step(C_LDP, 0);
        step(C_LDS, 0);
        step(C_DONE | C_LDS, 0);
        step(C_DONE | C_LDS, 0);
        chk("buf_full_in_ready", longint'(in_ready), 0);
        step(C_DONE, 0);
        chk("buf_drop_err", longint'(drop_err), 1);
        chk("buf_head1", longint'($signed(out_data)), 1);
        step(16'h0000, 1);
        chk("buf_head2", longint'($signed(out_data)), 2);
        step(16'h0000, 1);
        chk("buf_drained", longint'(out_valid), 0);

        // Reset mid-operation with S=100 and two queued entries
        set_ops(10, 10, 0);
        step(C_CLR | C_LDA | C_LDB, 0);
        step(C_LDP, 0);
        step(C_LDS, 0);
        step(C_DONE, 0);
        step(C_DONE, 0);
        control = '0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_in_ready", longint'(in_ready), 1);
        chk("arst_drop_err", longint'(drop_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(C_DONE, 0);
        chk("arst_s_cleared", longint'($signed(out_data)), 0);
        chk("arst_s_valid", longint'(out_valid), 1);
        step(16'h0000, 1);

        // Accumulate 9 x 65536 from A*A with A=-256
        set_ops(-256, -256, 0);
        step(C_CLR | C_LDA | C_LDB, 0);
        step(C_LDP | C_S11, 0);
        chk("model_p_aa", m_p, 65536);
        repeat (9) step(C_LDS, 0);
        step(C_DONE, 0);
`ifdef MAC_SAT_EN
        chk("sat_result", longint'($signed(out_data)), 524287);
`else
        chk("wrap_result", longint'($signed(out_data)), -458752);
`endif
        step(16'h0000, 1);
        step(16'h0000, 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
